// File: rtl/pin_entry_ctrl.sv
// PIN-entry controller: collects N_DIGITS nibbles into a shift buffer, drives the packed 7-segment bus, hands the code to the comparator.
// All outputs registered (1-cycle latency); pulse inputs are accepted or dropped in the cycle they arrive, no backpressure.
module pin_entry_ctrl #(
  parameter int         N_DIGITS      = 4,
  parameter int         BLINK_TICKS   = 12500,
  parameter int         TIMEOUT_TICKS = 125000,
  parameter logic [3:0] BLANK         = 4'hF
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            tick,
  input  logic                            enb_count,
  input  logic [4*N_DIGITS-1:0]           led_cnt_in,
  input  logic [3:0]                      value_4bit,
  input  logic                            confirm,
  input  logic                            backspace,
  input  logic                            clear,
  output logic [4*N_DIGITS-1:0]           led7_out,
  output logic [4*N_DIGITS-1:0]           pw_out,
  output logic                            pw_valid,
  output logic                            enough,
  output logic [$clog2(N_DIGITS+1)-1:0]   digit_count,
  output logic                            timeout
);

  localparam int DCW = $clog2(N_DIGITS + 1);
  localparam int BCW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam int TCW = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam bit TO_EN = (TIMEOUT_TICKS > 0);

  localparam logic [DCW-1:0] LAST   = DCW'(N_DIGITS - 1);
  localparam logic [DCW-1:0] FULL   = DCW'(N_DIGITS);
  localparam logic [BCW-1:0] B_LAST = BCW'(BLINK_TICKS - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_TICKS - 1);

  typedef enum logic {ENTRY, DONE} state_t;

  state_t                      state_q, state_d;
  logic [N_DIGITS-2:0][3:0]    dig_q, dig_d, dig_shl, dig_shr;
  logic [DCW-1:0]              cnt_d;
  logic [4*N_DIGITS-1:0]       pw_d, led_d;
  logic                        pw_valid_d, timeout_d;
  logic [BCW-1:0]              bcnt_q, bcnt_d;
  logic                        phase_q, phase_d;
  logic [TCW-1:0]              tcnt_q, tcnt_d;
  logic                        accepted, do_clear;

  // Buffer holds only the stored digits; the newest sits in slot 0, empty slots read BLANK.
  always_comb begin
    dig_shl    = dig_q;
    dig_shl[0] = value_4bit;
    for (int i = 1; i < N_DIGITS - 1; i++) begin
      dig_shl[i] = dig_q[i-1];
    end
    dig_shr             = dig_q;
    dig_shr[N_DIGITS-2] = BLANK;
    for (int i = 0; i < N_DIGITS - 2; i++) begin
      dig_shr[i] = dig_q[i+1];
    end
  end

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cnt_d      = digit_count;
    pw_d       = pw_out;
    pw_valid_d = 1'b0;
    timeout_d  = 1'b0;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    tcnt_d     = tcnt_q;
    accepted   = 1'b0;
    do_clear   = 1'b0;

    if (!enb_count) begin
      case (state_q)
        ENTRY: begin
          if (clear) begin
            accepted = 1'b1;
            do_clear = 1'b1;
          end else if (confirm) begin
            accepted = 1'b1;
            if (digit_count == LAST) begin
              pw_d       = {dig_q, value_4bit};
              pw_valid_d = 1'b1;
              cnt_d      = FULL;
              state_d    = DONE;
            end else begin
              dig_d = dig_shl;
              cnt_d = digit_count + 1'b1;
            end
          end else if (backspace && digit_count != '0) begin
            accepted = 1'b1;
            dig_d    = dig_shr;
            cnt_d    = digit_count - 1'b1;
          end else if (TO_EN && tick && digit_count != '0) begin
            if (tcnt_q == T_LAST) begin
              do_clear  = 1'b1;
              timeout_d = 1'b1;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (clear) begin
            accepted = 1'b1;
            do_clear = 1'b1;
            state_d  = ENTRY;
          end
        end
        default: state_d = ENTRY;
      endcase

      if (do_clear) begin
        dig_d = {(N_DIGITS-1){BLANK}};
        cnt_d = '0;
      end
      if (accepted || do_clear) begin
        tcnt_d = '0;
      end

      // Any user action restarts the cursor in its visible phase.
      if (accepted || timeout_d) begin
        phase_d = 1'b1;
        bcnt_d  = '0;
      end else if (tick) begin
        if (bcnt_q == B_LAST) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end

    if (enb_count) begin
      led_d = led_cnt_in;
    end else if (state_d == DONE) begin
      led_d = pw_d;
    end else begin
      led_d = {dig_d, (phase_d ? value_4bit : BLANK)};
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= ENTRY;
      dig_q       <= {(N_DIGITS-1){BLANK}};
      digit_count <= '0;
      pw_out      <= {N_DIGITS{BLANK}};
      led7_out    <= {N_DIGITS{BLANK}};
      pw_valid    <= 1'b0;
      enough      <= 1'b0;
      timeout     <= 1'b0;
      bcnt_q      <= '0;
      phase_q     <= 1'b1;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      digit_count <= cnt_d;
      pw_out      <= pw_d;
      led7_out    <= led_d;
      pw_valid    <= pw_valid_d;
      enough      <= (state_d == DONE);
      timeout     <= timeout_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      tcnt_q      <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Directed bench for pin_entry_ctrl: a 4-digit instance with short blink/timeout and a 6-digit instance with timeout disabled.
module tb_pin_entry_ctrl;

  typedef enum logic [2:0] {OP_IDLE, OP_TICK, OP_CONF, OP_BACK, OP_CLR, OP_CLRCONF} op_e;

  typedef struct {
    op_e         op;
    logic [3:0]  val;
    logic [2:0]  cnt;
    logic [15:0] led;
    logic [15:0] pw;
    logic        en;
    logic        pwv;
    logic        to;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        enb_count = 1'b0;
  logic [3:0]  value_4bit = 4'h0;
  logic        confirm = 1'b0;
  logic        backspace = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] led_cnt4 = 16'h0042;
  logic [23:0] led_cnt6 = 24'h000042;

  logic [15:0] led4, pw4;
  logic        pwv4, en4, to4;
  logic [2:0]  cnt4;
  logic [23:0] led6, pw6;
  logic        pwv6, en6, to6;
  logic [2:0]  cnt6;

  int errors = 0;
  int checks = 0;
  vec_t tv[$];

  pin_entry_ctrl #(.N_DIGITS(4), .BLINK_TICKS(2), .TIMEOUT_TICKS(5), .BLANK(4'hF)) u_dut4 (
    .clk_in(clk_in), .reset(reset), .tick(tick), .enb_count(enb_count),
    .led_cnt_in(led_cnt4), .value_4bit(value_4bit), .confirm(confirm),
    .backspace(backspace), .clear(clear), .led7_out(led4), .pw_out(pw4),
    .pw_valid(pwv4), .enough(en4), .digit_count(cnt4), .timeout(to4)
  );

  pin_entry_ctrl #(.N_DIGITS(6), .BLINK_TICKS(2), .TIMEOUT_TICKS(0), .BLANK(4'hF)) u_dut6 (
    .clk_in(clk_in), .reset(reset), .tick(tick), .enb_count(enb_count),
    .led_cnt_in(led_cnt6), .value_4bit(value_4bit), .confirm(confirm),
    .backspace(backspace), .clear(clear), .led7_out(led6), .pw_out(pw6),
    .pw_valid(pwv6), .enough(en6), .digit_count(cnt6), .timeout(to6)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply(input op_e op, input logic [3:0] v);
    value_4bit = v;
    confirm    = (op == OP_CONF) || (op == OP_CLRCONF);
    backspace  = (op == OP_BACK);
    clear      = (op == OP_CLR) || (op == OP_CLRCONF);
    tick       = (op == OP_TICK);
    step();
    confirm    = 1'b0;
    backspace  = 1'b0;
    clear      = 1'b0;
    tick       = 1'b0;
  endtask

  function automatic vec_t mk(op_e op, logic [3:0] v, logic [2:0] c, logic [15:0] l,
                              logic [15:0] p, logic e, logic pv, logic t);
    vec_t r;
    r.op = op; r.val = v; r.cnt = c; r.led = l; r.pw = p; r.en = e; r.pwv = pv; r.to = t;
    return r;
  endfunction

  task automatic chk_reset6(input string tag);
    chk({tag, " led6"}, led6, 24'hFFFFFF);
    chk({tag, " pw6"},  pw6,  24'hFFFFFF);
    chk({tag, " cnt6"}, cnt6, 0);
    chk({tag, " en6"},  en6,  0);
    chk({tag, " pwv6"}, pwv6, 0);
    chk({tag, " to6"},  to6,  0);
  endtask

  initial begin
    // Entry, backspace, blink, clear+confirm, full code, DONE, timeout
    tv.push_back(mk(OP_IDLE,    4'h5, 0, 16'hFFF5, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h7, 1, 16'hFF77, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h8, 2, 16'hF788, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_BACK,    4'h5, 1, 16'hFF75, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h5, 1, 16'hFF75, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h5, 1, 16'hFF7F, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h5, 1, 16'hFF7F, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h5, 1, 16'hFF75, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h2, 2, 16'hF722, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CLRCONF, 4'h3, 0, 16'hFFF3, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_BACK,    4'h3, 0, 16'hFFF3, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h3, 0, 16'hFFF3, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h3, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h3, 0, 16'hFFFF, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h3, 0, 16'hFFF3, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h3, 0, 16'hFFF3, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h1, 1, 16'hFF11, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h2, 2, 16'hF122, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h3, 3, 16'h1233, 16'hFFFF, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h4, 4, 16'h1234, 16'h1234, 1, 1, 0));
    tv.push_back(mk(OP_IDLE,    4'h4, 4, 16'h1234, 16'h1234, 1, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h4, 4, 16'h1234, 16'h1234, 1, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h4, 4, 16'h1234, 16'h1234, 1, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h9, 4, 16'h1234, 16'h1234, 1, 0, 0));
    tv.push_back(mk(OP_BACK,    4'h9, 4, 16'h1234, 16'h1234, 1, 0, 0));
    tv.push_back(mk(OP_CLR,     4'h6, 0, 16'hFFF6, 16'h1234, 0, 0, 0));
    tv.push_back(mk(OP_CONF,    4'h1, 1, 16'hFF11, 16'h1234, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h1, 1, 16'hFF11, 16'h1234, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h1, 1, 16'hFF1F, 16'h1234, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h1, 1, 16'hFF1F, 16'h1234, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h1, 1, 16'hFF11, 16'h1234, 0, 0, 0));
    tv.push_back(mk(OP_TICK,    4'h1, 0, 16'hFFF1, 16'h1234, 0, 0, 1));
    tv.push_back(mk(OP_IDLE,    4'h1, 0, 16'hFFF1, 16'h1234, 0, 0, 0));

    #3 reset = 1'b0;
    step();
    step();
    chk("rst led4", led4, 16'hFFFF);
    chk("rst pw4",  pw4,  16'hFFFF);
    chk("rst cnt4", cnt4, 0);
    chk("rst en4",  en4,  0);
    chk("rst pwv4", pwv4, 0);
    chk("rst to4",  to4,  0);
    chk_reset6("rst");
    reset = 1'b1;

    foreach (tv[i]) begin
      apply(tv[i].op, tv[i].val);
      chk($sformatf("v%0d cnt", i),   cnt4, tv[i].cnt);
      chk($sformatf("v%0d led", i),   led4, tv[i].led);
      chk($sformatf("v%0d pw", i),    pw4,  tv[i].pw);
      chk($sformatf("v%0d enough", i), en4, tv[i].en);
      chk($sformatf("v%0d pwv", i),   pwv4, tv[i].pwv);
      chk($sformatf("v%0d tmo", i),   to4,  tv[i].to);
    end

    // Counter-display mode freezes entry, blink and timeout
    apply(OP_CONF, 4'h4);
    chk("cm pre cnt", cnt4, 1);
    chk("cm pre led", led4, 16'hFF44);
    enb_count = 1'b1;
    apply(OP_CONF, 4'h9);
    chk("cm conf led", led4, 16'h0042);
    chk("cm conf cnt", cnt4, 1);
    apply(OP_BACK, 4'h9);
    chk("cm back cnt", cnt4, 1);
    apply(OP_CLR, 4'h9);
    chk("cm clr cnt", cnt4, 1);
    chk("cm clr led", led4, 16'h0042);
    for (int k = 0; k < 5; k++) begin
      apply(OP_TICK, 4'h9);
      chk($sformatf("cm tick%0d tmo", k), to4, 0);
      chk($sformatf("cm tick%0d cnt", k), cnt4, 1);
    end
    enb_count = 1'b0;
    apply(OP_IDLE, 4'h4);
    chk("cm exit led", led4, 16'hFF44);
    apply(OP_TICK, 4'h4);
    chk("cm hold t1 led", led4, 16'hFF44);
    apply(OP_TICK, 4'h4);
    chk("cm hold t2 led", led4, 16'hFF4F);

    // Asynchronous reset mid-cycle
    reset = 1'b0;
    #2;
    chk("ar led4", led4, 16'hFFFF);
    chk("ar cnt4", cnt4, 0);
    chk("ar pw4",  pw4,  16'hFFFF);
    chk_reset6("ar");
    step();
    reset = 1'b1;

    // Six-digit code on the wide instance
    apply(OP_CONF, 4'h9);
    apply(OP_CONF, 4'h8);
    apply(OP_CONF, 4'h7);
    apply(OP_CONF, 4'h6);
    apply(OP_CONF, 4'h5);
    chk("n6 cnt5", cnt6, 5);
    chk("n6 pwv early", pwv6, 0);
    apply(OP_CONF, 4'h4);
    chk("n6 pw",   pw6,  24'h987654);
    chk("n6 pwv",  pwv6, 1);
    chk("n6 en",   en6,  1);
    chk("n6 cnt",  cnt6, 6);
    chk("n6 led",  led6, 24'h987654);
    apply(OP_IDLE, 4'h4);
    chk("n6 pwv drop", pwv6, 0);
    apply(OP_CLR, 4'h0);
    chk("n6 clr cnt", cnt6, 0);
    chk("n6 clr pw",  pw6,  24'h987654);
    apply(OP_CONF, 4'h1);
    apply(OP_CONF, 4'h2);
    apply(OP_CONF, 4'h3);
    chk("n6 part cnt", cnt6, 3);
    chk("n6 part led", led6, 24'hFF1233);
    for (int k = 0; k < 7; k++) begin
      apply(OP_TICK, 4'h3);
      chk($sformatf("n6 notmo%0d", k), to6, 0);
    end
    chk("n6 notmo cnt", cnt6, 3);
    reset = 1'b0;
    #2;
    chk_reset6("n6 ar");
    step();
    reset = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pin_entry_ctrl.md
Name: pin_entry_ctrl

Overview:
- Parametrised PIN-entry controller for the electronic lock; successor to the fixed 4-digit entry/display block.
- Collects N_DIGITS 4-bit digits from the value selector on debounced confirm pulses and supports backspace, clear and inactivity timeout.
- Drives the packed 7-segment digit bus with a blinking cursor, and hands the completed code to the lock comparator with a valid pulse.
- Fully synchronous to clk_in; the blink and timeout timebase comes from an external tick enable, not a derived clock.

Parameters:
- N_DIGITS, 4, number of PIN digits (2..8).
- BLINK_TICKS, 12500, tick count per cursor blink half-period.
- TIMEOUT_TICKS, 125000, ticks of inactivity before entry is discarded; 0 disables the timeout.
- BLANK, 4'hF, nibble code that renders a dark digit.

Ports:
- clk_in  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase enable.
- enb_count  in  1  counter-display mode; entry is frozen while high.
- led_cnt_in  in  4*N_DIGITS  counter digits shown when enb_count=1.
- value_4bit  in  4  currently selected digit (cursor value).
- confirm  in  1  one-cycle, pre-debounced pulse that enters a digit.
- backspace  in  1  one-cycle pulse that deletes the last digit.
- clear  in  1  one-cycle pulse that discards the entry.
- led7_out  out  4*N_DIGITS  packed display nibbles; nibble 0 is rightmost.
- pw_out  out  4*N_DIGITS  completed code, first-entered digit in the top nibble.
- pw_valid  out  1  one-cycle pulse when pw_out updates.
- enough  out  1  high while in DONE.
- digit_count  out  $clog2(N_DIGITS+1)  number of digits entered.
- timeout  out  1  one-cycle pulse when an inactivity timeout fires.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state ENTRY;
  - all stored digits, led7_out and pw_out to all-BLANK;
  - pw_valid, enough, timeout and digit_count to 0;
  - blink phase to on, blink and timeout counters to 0.
- States:
  - ENTRY: confirm with digit_count < N_DIGITS-1 shifts value_4bit into the digit buffer and increments digit_count.
  - ENTRY: confirm with digit_count = N_DIGITS-1 loads pw_out = {stored digits, value_4bit}, pulses pw_valid for one cycle, sets digit_count=N_DIGITS and enough=1, and moves to DONE. The pw_valid pulse occurs in the cycle after confirm.
  - DONE: confirm, backspace and timeout are ignored. clear returns to ENTRY and empties the buffer; pw_out is retained.
- Backspace in ENTRY:
  - with digit_count > 0, drops the most recent digit and decrements digit_count;
  - with digit_count = 0, no effect.
- Clear in ENTRY: empties the buffer and sets digit_count=0. pw_out is unchanged.
- Event priority when pulses coincide: clear > confirm > backspace. A lower-priority pulse in the same cycle is dropped.
- Counter-display mode (enb_count=1):
  - confirm, backspace and clear are ignored;
  - the blink and timeout counters hold;
  - led7_out = led_cnt_in, registered with 1-cycle latency.
- Display while in ENTRY with enb_count=0 (registered, 1-cycle latency):
  - nibble 0 is value_4bit when blink phase is on, BLANK when off;
  - nibbles 1..digit_count hold the entered digits, most recent at nibble 1;
  - higher nibbles are BLANK.
- Display in DONE: led7_out = pw_out, with no blink.
- Blink:
  - the counter advances on tick;
  - at BLINK_TICKS-1 it wraps to 0 and toggles the phase;
  - any accepted confirm, backspace or clear forces phase=on and counter=0.
- Timeout:
  - applies only in ENTRY with digit_count > 0;
  - the counter advances on tick and resets to 0 on any accepted event;
  - reaching TIMEOUT_TICKS performs a clear and pulses timeout for one cycle;
  - when TIMEOUT_TICKS=0 the counter is disabled and timeout stays 0.
- Width rules:
  - digit_count saturates at N_DIGITS;
  - internal counters are sized $clog2 of their terminal value, minimum 1 bit;
  - there is no wrap-around of the digit buffer.
- Reset asserted mid-entry or in DONE returns immediately to the reset values; no pw_valid is issued.

Test Plan:
- N_DIGITS=4, BLINK_TICKS=2: confirm with value 1, 2, 3, then 4 -> pw_out=16'h1234, pw_valid one cycle after the 4th confirm, enough=1, led7_out=16'h1234 steady.
- Two digits 7, 8 entered then backspace, cursor value 5 -> digit_count=1, led7_out=16'hFF75 with blink on; nibble 0 toggles to F every 2 ticks.
- Clear and confirm in the same cycle with digit_count=2 -> digit_count=0, led7_out=16'hFFF{value}, no digit stored.
- TIMEOUT_TICKS=5, one digit entered, 5 idle ticks -> timeout pulse, digit_count=0; with digit_count=0, idle ticks produce no pulse.
- enb_count=1 with led_cnt_in=16'h0042 and confirm pulses -> led7_out=16'h0042, digit_count unchanged; dropping enb_count restores the entry display.
- N_DIGITS=6: six confirms -> 24-bit pw_out correct. Reset asserted after 3 digits -> all outputs return to reset values asynchronously.
